// File: rtl/ram_master.sv
// Bus master for the single-port RAM: turns command / write-data / read-response
// handshakes into wr_en, addr and tristate data, with wrapping incrementing bursts.
module ram_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [DATA_WIDTH-1:0] wd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  busy,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  typedef enum logic [1:0] {IDLE, WR, RD} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  beats_q, beats_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  ram_wr_en_q, ram_wr_en_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic                  pend_q, pend_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_last_q, rd_last_d;
  logic                  rd_cap;

  // The write-enable flop is also the output enable, so direction flips on one edge.
  assign ram_data  = ram_wr_en_q ? wdata_q : {DATA_WIDTH{1'bz}};
  assign ram_wr_en = ram_wr_en_q;
  assign ram_addr  = ram_addr_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_last   = rd_last_q;
  assign cmd_ready = rst_n && (state_q == IDLE);
  assign wd_ready  = rst_n && (state_q == WR);
  assign busy      = (state_q != IDLE) || ram_wr_en_q || pend_q;
  assign rd_cap    = pend_q && (!rd_valid_q || rd_ready);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    beats_d     = beats_q;
    wdata_d     = wdata_q;
    ram_wr_en_d = 1'b0;
    ram_addr_d  = ram_addr_q;
    pend_d      = pend_q;
    rd_valid_d  = (rd_valid_q && !rd_ready);
    rd_data_d   = rd_data_q;
    rd_last_d   = rd_last_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d  = cmd_addr;
          beats_d = cmd_len;
          if (cmd_we) begin
            state_d = WR;
          end else begin
            state_d    = RD;
            ram_addr_d = cmd_addr;
            pend_d     = 1'b1;
          end
        end
      end
      WR: begin
        if (wd_valid) begin
          ram_wr_en_d = 1'b1;
          ram_addr_d  = addr_q;
          wdata_d     = wd_data;
          addr_d      = addr_q + 1'b1;
          if (beats_q == '0) state_d = IDLE;
          else               beats_d = beats_q - 1'b1;
        end
      end
      RD: begin
        // The RAM presents mem[ram_addr] combinationally, so capture it directly.
        if (rd_cap) begin
          rd_data_d  = ram_data;
          rd_valid_d = 1'b1;
          rd_last_d  = (beats_q == '0);
          if (beats_q == '0) begin
            pend_d  = 1'b0;
            state_d = IDLE;
          end else begin
            ram_addr_d = ram_addr_q + 1'b1;
            beats_d    = beats_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      beats_q     <= '0;
      wdata_q     <= '0;
      ram_wr_en_q <= 1'b0;
      ram_addr_q  <= '0;
      pend_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_last_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of order.
      state_q     <= state_d;
      addr_q      <= addr_d;
      beats_q     <= beats_d;
      wdata_q     <= wdata_d;
      ram_wr_en_q <= ram_wr_en_d;
      ram_addr_q  <= ram_addr_d;
      pend_q      <= pend_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      rd_last_q   <= rd_last_d;
    end
  end

endmodule

// File: tb/tb_ram_master.sv
// Self-checking bench for ram_master: behavioural RAM on the shared bus, an
// array model of memory contents, and a log of expected write pulses.
module tb_ram_master;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          wd_valid = 1'b0;
  logic [DW-1:0] wd_data = '0;
  logic          rd_ready = 1'b1;
  logic          cmd_ready, wd_ready, rd_valid, rd_last, busy, ram_wr_en;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] ram_addr;
  wire  [DW-1:0] ram_data;

  always #5 clk = ~clk;

  ram_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .ram_wr_en(ram_wr_en), .ram_addr(ram_addr), .ram_data(ram_data)
  );

  // Single-port RAM: commits on the rising edge, drives the bus when not written.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (ram_wr_en) mem[ram_addr] <= ram_data;
  assign ram_data = ram_wr_en ? {DW{1'bz}} : mem[ram_addr];

  logic [AW+DW-1:0] wr_seen[$];
  always @(posedge clk) if (ram_wr_en) wr_seen.push_back({ram_addr, ram_data});

  int               n_checks = 0;
  int               n_fail = 0;
  logic [DW-1:0]    ref_mem [DEPTH];
  logic [AW+DW-1:0] wr_exp[$];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic we, input logic [AW-1:0] a, input logic [LW-1:0] l);
    int t = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = l;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    check("cmd_accept", DW'(cmd_ready), DW'(1));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [AW-1:0] wa, input logic [DW-1:0] d);
    int t = 0;
    @(negedge clk);
    wd_valid = 1'b1; wd_data = d;
    while (!wd_ready && t < 50) begin @(negedge clk); t++; end
    check("wd_accept", DW'(wd_ready), DW'(1));
    @(posedge clk); #1;
    wd_valid = 1'b0;
    ref_mem[wa] = d;
    wr_exp.push_back({wa, d});
  endtask

  task automatic write_burst(input logic [AW-1:0] a, input logic [LW-1:0] l,
                             input logic [DW-1:0] base, input bit inc,
                             input int gap_at, input int gap_len);
    send_cmd(1'b1, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          if (g > 0) check("wr_en_gap", DW'(ram_wr_en), DW'(0));
        end
      end
      send_beat(a + AW'(i), inc ? base + DW'(i) : DW'($urandom));
    end
  endtask

  task automatic check_writes();
    repeat (2) @(negedge clk);
    check("wr_count", DW'(wr_seen.size()), DW'(wr_exp.size()));
    for (int i = 0; i < wr_exp.size() && i < wr_seen.size(); i++) begin
      check("wr_addr", DW'(wr_seen[i][AW+DW-1:DW]), DW'(wr_exp[i][AW+DW-1:DW]));
      check("wr_data", wr_seen[i][DW-1:0], wr_exp[i][DW-1:0]);
    end
    wr_seen.delete();
    wr_exp.delete();
  endtask

  task automatic read_burst(input logic [AW-1:0] a, input logic [LW-1:0] l, input int stall);
    int got = 0, t = 0, first_t = -1, st = stall;
    send_cmd(1'b0, a, l);
    rd_ready = 1'b1;
    while (got <= int'(l) && t < 200) begin
      @(negedge clk); t++;
      if (got == 1 && st > 0) begin
        rd_ready = 1'b0; st--;
        check("stall_valid", DW'(rd_valid), DW'(1));
        check("stall_data", rd_data, ref_mem[a + AW'(1)]);
        check("stall_addr", DW'(ram_addr), DW'(a + AW'(2)));
      end else begin
        rd_ready = 1'b1;
        if (rd_valid) begin
          if (got == 0) first_t = t;
          check("rd_data", rd_data, ref_mem[a + AW'(got)]);
          check("rd_last", DW'(rd_last), DW'(got == int'(l)));
          got++;
        end
      end
    end
    check("rd_beats", DW'(got), DW'(int'(l) + 1));
    check("rd_latency", DW'(first_t), DW'(2));
    @(negedge clk);
    check("rd_drained", DW'({rd_valid, busy}), DW'(0));
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [LW-1:0] rl;
    repeat (3) @(negedge clk);
    check("rst_wr_en", DW'(ram_wr_en), DW'(0));
    check("rst_addr", DW'(ram_addr), DW'(0));
    check("rst_rd", DW'({rd_valid, rd_last}), DW'(0));
    check("rst_rd_data", rd_data, DW'(0));
    check("rst_ready", DW'({cmd_ready, wd_ready, busy}), DW'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", DW'(cmd_ready), DW'(1));

    // Fill the whole RAM so later reads have known contents.
    write_burst(0, 15, '0, 1'b0, -1, 0);
    check_writes();

    // Single write then a read accepted on the commit edge.
    write_burst(3, 0, 32'hDEADBEEF, 1'b1, -1, 0);
    read_burst(3, 0, 0);
    check("rd_deadbeef", ref_mem[3], 32'hDEADBEEF);
    check_writes();

    // Wrapping burst 14,15,0,1.
    write_burst(14, 3, 32'd1, 1'b1, -1, 0);
    read_burst(14, 3, 0);
    check_writes();

    // Two idle cycles between the second and third beats.
    write_burst(5, 2, '0, 1'b0, 2, 2);
    check_writes();

    // Consumer stalls three cycles after the first beat.
    read_burst(4, 3, 3);

    for (int k = 0; k < 8; k++) begin
      ra = AW'($urandom);
      rl = LW'($urandom_range(5, 0));
      if ($urandom_range(1, 0) == 1) begin
        write_burst(ra, rl, '0, 1'b0, $urandom_range(int'(rl), 0), $urandom_range(3, 0));
        check_writes();
      end else begin
        read_burst(ra, rl, (rl >= 2) ? $urandom_range(3, 0) : 0);
      end
    end

    // Reset in the middle of a 4-beat write after two beats.
    send_cmd(1'b1, 8, 3);
    send_beat(8, DW'($urandom));
    send_beat(9, DW'($urandom));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_wr_en", DW'(ram_wr_en), DW'(0));
    check("mid_rst_ready", DW'({cmd_ready, wd_ready}), DW'(0));
    check("mid_rst_rd", DW'({rd_valid, busy}), DW'(0));
    check("mid_rst_addr", DW'(ram_addr), DW'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_writes();
    check("post_rst_idle", DW'({cmd_ready, busy}), DW'(2));
    read_burst(8, 3, 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
